// File: rtl/spi_pkg.sv
// Shared constants, register map and FSM state type for the SPI controller.
// The optional read path is enabled by defining SPI_CTRL_READ_EN.
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    // spi_peripheral register map
    localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;
    localparam logic [ADDR_W-1:0] MAX_ADDR        = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Largest of three timing parameters, used to size the phase timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request/response handshake between a requester and spi_controller.
// rsp_data exists only when SPI_CTRL_READ_EN is defined.
interface spi_controller_if;
    import spi_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              busy;
    logic              done;
`ifdef SPI_CTRL_READ_EN
    logic [DATA_W-1:0] rsp_data;
`endif

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_data,
        input  req_ready,
        input  busy,
        input  done
`ifdef SPI_CTRL_READ_EN
        , input rsp_data
`endif
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_data,
        output req_ready,
        output busy,
        output done
`ifdef SPI_CTRL_READ_EN
        , output rsp_data
`endif
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: sclk toggles every CLK_DIV clk cycles while enabled.
// rise/fall are one-cycle strobes in the last cycle before sclk changes level.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             wrap_s;

    // Divider next-state: reload at CLK_DIV-1 and toggle sclk; park low when disabled.
    always_comb begin
        wrap_s = en && (cnt_q == CNT_LAST);
        if (!en) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            sclk_d = sclk_q;
        end
    end

    // Divider registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;
    assign rise = wrap_s && !sclk_q;
    assign fall = wrap_s && sclk_q;

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: sends {write, addr[6:0], data[7:0]} MSB-first per request.
// Define SPI_CTRL_READ_EN to add cipo capture into bus.rsp_data on read frames.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_controller_if.slave  bus,
    output logic             sclk,
    output logic             ncs,
    output logic             copi
`ifdef SPI_CTRL_READ_EN
    , input  logic           cipo
`endif
);

    localparam int TMR_W = $clog2(max3(CS_SETUP, CS_HOLD, CS_IDLE) + 1);
    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(CS_HOLD - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(CS_IDLE - 1);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;     // sclk rises seen this frame, 0..16
    logic [FRAME_W-2:0] shreg_q, shreg_d;         // frame bits still to be sent after copi
    logic               copi_q, copi_d;
    logic               ncs_q, ncs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               req_ready_q, req_ready_d;
    logic               accept_s;
    logic               rise_s, fall_s;
`ifdef SPI_CTRL_READ_EN
    logic               rd_q, rd_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  rsp_q, rsp_d;
`endif

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_SHIFT),
        .sclk (sclk),
        .rise (rise_s),
        .fall (fall_s)
    );

    // Frame sequencing and next values of all registered outputs.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        copi_d    = copi_q;
`ifdef SPI_CTRL_READ_EN
        rd_d      = rd_q;
        rx_d      = rx_q;
        rsp_d     = rsp_q;
`endif
        accept_s  = (state_q == ST_IDLE) && bus.req_valid && req_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_SETUP;
                    tmr_d     = SETUP_LD;
                    bit_cnt_d = 5'd0;
                    copi_d    = bus.req_write;
                    shreg_d   = {bus.req_addr, bus.req_data};
`ifdef SPI_CTRL_READ_EN
                    rd_d      = !bus.req_write;
`endif
                end else begin
                    copi_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tmr_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_SHIFT: begin
                if (rise_s) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
`ifdef SPI_CTRL_READ_EN
                // Bits 7..0 are the 9th..16th rises; sample at the end of each high phase.
                if (fall_s && rd_q && (bit_cnt_q >= 5'd9)) begin
                    rx_d = {rx_q[DATA_W-2:0], cipo};
                end else begin
                    rx_d = rx_q;
                end
`endif
                if (fall_s) begin
                    if (bit_cnt_q == 5'd16) begin
                        state_d = ST_HOLD;
                        tmr_d   = HOLD_LD;
                        copi_d  = 1'b0;
                    end else begin
                        copi_d  = shreg_q[FRAME_W-2];
                        shreg_d = {shreg_q[FRAME_W-3:0], 1'b0};
                    end
                end else begin
                    copi_d = copi_q;
                end
            end
            ST_HOLD: begin
                if (tmr_q == '0) begin
                    state_d = ST_GAP;
                    tmr_d   = GAP_LD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                copi_d  = 1'b0;
            end
        endcase

        // Outputs follow the next state so every pin comes straight from a flop.
        ncs_d       = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
        busy_d      = (state_d != ST_IDLE);
        req_ready_d = (state_d == ST_IDLE);
        done_d      = (state_d == ST_GAP) && (tmr_d == '0);
`ifdef SPI_CTRL_READ_EN
        if (done_d && rd_q) begin
            rsp_d = rx_q;
        end else begin
            rsp_d = rsp_q;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            bit_cnt_q   <= 5'd0;
            shreg_q     <= '0;
            copi_q      <= 1'b0;
            ncs_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b0;
`ifdef SPI_CTRL_READ_EN
            rd_q        <= 1'b0;
            rx_q        <= '0;
            rsp_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            copi_q      <= copi_d;
            ncs_q       <= ncs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_ready_q <= req_ready_d;
`ifdef SPI_CTRL_READ_EN
            rd_q        <= rd_d;
            rx_q        <= rx_d;
            rsp_q       <= rsp_d;
`endif
        end
    end

    assign ncs           = ncs_q;
    assign copi          = copi_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.req_ready = req_ready_q;
`ifdef SPI_CTRL_READ_EN
    assign bus.rsp_data  = rsp_q;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller with a behavioural frame decoder standing in
// for spi_peripheral. Define SPI_CTRL_READ_EN to also exercise the read path.
module tb_spi_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk, ncs, copi;

    spi_controller_if bus();

`ifdef SPI_CTRL_READ_EN
    logic       cipo_s;
    logic [7:0] rd_byte = 8'h3C;
    logic [7:0] rsp_at_done = 8'h00;
`endif

    spi_controller #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .sclk (sclk),
        .ncs  (ncs),
        .copi (copi)
`ifdef SPI_CTRL_READ_EN
        , .cipo (cipo_s)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Monitor / peripheral model state
    int          cyc = 0;
    logic        sclk_p = 1'b0, ncs_p = 1'b1, copi_p = 1'b0;
    int          rise_cnt = 0;
    logic [15:0] frame = 16'h0000;
    logic [15:0] last_frame = 16'h0000;
    int          last_rises = 0;
    int          ncs_low = 0, last_low = 0;
    int          high_cnt = 0, last_gap = 0;
    int          done_cnt = 0;
    int          stab_err = 0;
    int          acc_n = 0;
    int          acc_t [0:15];
    logic [7:0]  regs [0:127];

    initial begin
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        for (int i = 0; i < 16; i++) acc_t[i] = 0;
    end

`ifdef SPI_CTRL_READ_EN
    // Peripheral returns read data MSB-first during the data-byte high phases.
    always_comb begin
        cipo_s = 1'b0;
        if (rise_cnt >= 9 && rise_cnt <= 16) cipo_s = rd_byte[16 - rise_cnt];
    end
`endif

    // Sample the bus away from the active edge and decode frames like the peripheral would.
    always @(negedge clk) begin
        cyc    <= cyc + 1;
        sclk_p <= sclk;
        ncs_p  <= ncs;
        copi_p <= copi;
        if (!ncs && ncs_p) begin
            rise_cnt <= 0;
            last_gap <= high_cnt;
        end else if (sclk && !sclk_p && !ncs) begin
            rise_cnt <= rise_cnt + 1;
            frame    <= {frame[14:0], copi};
        end
        if (sclk && sclk_p && (copi != copi_p)) stab_err <= stab_err + 1;
        if (!ncs) ncs_low  <= ncs_p ? 1 : ncs_low + 1;
        if (ncs)  high_cnt <= !ncs_p ? 1 : high_cnt + 1;
        if (ncs && !ncs_p) begin
            last_frame <= frame;
            last_rises <= rise_cnt;
            last_low   <= ncs_low;
            if (rise_cnt == 16 && frame[15]) regs[frame[14:8]] <= frame[7:0];
        end
        if (bus.done) begin
            done_cnt <= done_cnt + 1;
`ifdef SPI_CTRL_READ_EN
            rsp_at_done <= bus.rsp_data;
`endif
        end
        if (bus.req_valid && bus.req_ready) begin
            acc_t[acc_n] <= cyc;
            acc_n        <= acc_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_data  = d;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0;
        int n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(tag, done_cnt - d0, 32'd1);
    endtask

    initial begin
        int t0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 7'h00;
        bus.req_data  = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_sclk",  {31'd0, sclk}, 32'd0);
        check("rst_ncs",   {31'd0, ncs}, 32'd1);
        check("rst_copi",  {31'd0, copi}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_done",  {31'd0, bus.done}, 32'd0);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
`ifdef SPI_CTRL_READ_EN
        check("rst_rsp", {24'd0, bus.rsp_data}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

        // 1: write 0x00/0xF0
        send(1'b1, 7'h00, 8'hF0);
        @(negedge clk);
        check("busy_in_frame", {31'd0, bus.busy}, 32'd1);
        wait_done("t1_done");
        check("t1_frame", {16'd0, last_frame}, 32'h80F0);
        check("t1_reg0", {24'd0, regs[0]}, 32'hF0);

        // 2: write 0x04/0x80 timing
        send(1'b1, 7'h04, 8'h80);
        wait_done("t2_done_once");
        check("t2_frame", {16'd0, last_frame}, 32'h8480);
        check("t2_rises", last_rises, 32'd16);
        check("t2_ncs_low", last_low, 32'd132);
        check("t2_reg4", {24'd0, regs[4]}, 32'h80);
        check("t2_copi_stable", stab_err, 32'd0);

        // 3: req_valid held high across three writes
        t0 = acc_n;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 7'h01;
        bus.req_data  = 8'hAA;
        wait_ready();
        @(posedge clk); #1;
        bus.req_addr  = 7'h02;
        bus.req_data  = 8'h55;
        wait_ready();
        @(posedge clk); #1;
        bus.req_addr  = 7'h03;
        bus.req_data  = 8'hFF;
        wait_ready();
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_done("t3_done");
        repeat (2) @(negedge clk);
        check("t3_accepts", acc_n - t0, 32'd3);
        check("t3_period_a", acc_t[t0 + 1] - acc_t[t0], 32'd137);
        check("t3_period_b", acc_t[t0 + 2] - acc_t[t0 + 1], 32'd137);
        check("t3_gap", last_gap, 32'd5);
        check("t3_reg1", {24'd0, regs[1]}, 32'hAA);
        check("t3_reg2", {24'd0, regs[2]}, 32'h55);
        check("t3_reg3", {24'd0, regs[3]}, 32'hFF);

        // 4: reset in the middle of a frame
        send(1'b1, 7'h01, 8'h12);
        begin
            int n = 0;
            while (rise_cnt != 9 && n < 1000) begin
                @(negedge clk);
                n++;
            end
        end
        check("t4_reached_bit9", rise_cnt, 32'd9);
        rst = 1'b1;
        @(negedge clk);
        check("t4_ncs", {31'd0, ncs}, 32'd1);
        check("t4_sclk", {31'd0, sclk}, 32'd0);
        check("t4_busy", {31'd0, bus.busy}, 32'd0);
        check("t4_copi", {31'd0, copi}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_reg1_kept", {24'd0, regs[1]}, 32'hAA);
        send(1'b1, 7'h01, 8'h5A);
        wait_done("t4_retry_done");
        check("t4_reg1_new", {24'd0, regs[1]}, 32'h5A);

        // 5: inputs changed after accept must not affect the frame
        send(1'b1, 7'h03, 8'h11);
        bus.req_addr = 7'h7F;
        bus.req_data = 8'hEE;
        bus.req_write = 1'b0;
        wait_done("t5_done");
        check("t5_frame", {16'd0, last_frame}, 32'h8311);
        check("t5_reg3", {24'd0, regs[3]}, 32'h11);

`ifdef SPI_CTRL_READ_EN
        // 6: read addr 0x02, peripheral returns 0x3C
        send(1'b0, 7'h02, 8'h00);
        wait_done("t6_done");
        check("t6_frame", {16'd0, last_frame}, 32'h0200);
        check("t6_rsp_at_done", {24'd0, rsp_at_done}, 32'h3C);
        check("t6_reg2_kept", {24'd0, regs[2]}, 32'h55);
        send(1'b1, 7'h00, 8'h0F);
        wait_done("t6_wr_done");
        check("t6_rsp_unchanged", {24'd0, bus.rsp_data}, 32'h3C);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
